// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The CHK state is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         IMEM_DEPTH     = 4096;
  localparam int         BYTES_PER_WORD = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_W2,
    S_W1,
    S_W0,
    S_WRITE,
    S_CHK,
    S_ERROR
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles three stream bytes (B2, B1, B0) into one DATA_W-bit instruction and
// flags a B2 byte whose bits above the instruction width are non-zero.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              viol_o
);

  localparam logic [7:0] B2_MASK = 8'(8'hFF << (DATA_W - 16));

  logic [15:0] sr_q;
  logic [1:0]  idx_q;

  // word_o already includes the byte being accepted, so the top can latch
  // the finished word on the same edge that takes B0.
  assign word_o = DATA_W'({sr_q, byte_i});
  assign viol_o = (idx_q == 2'd0) && |(byte_i & B2_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {sr_q[7:0], byte_i};
      idx_q <= (idx_q == 2'(BYTES_PER_WORD - 1)) ? 2'd0 : idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Framed byte-stream loader for the instruction memory: header parse, 3-byte
// word packing, one write strobe per word. Optional trailing XOR checksum
// byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         ADDR_W    = 12,
  parameter int         DATA_W    = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [7:0]  ADDR_HI_MASK = 8'(8'hFF << (ADDR_W - 8));
  localparam logic [15:0] MAX_CNT      = 16'(IMEM_DEPTH);

  state_e            state_q, state_d;
  logic              acc, start, fin, wr_go, shift, chk_en;
  logic [7:0]        hi_q;
  logic [15:0]       cnt_in, rem_q;
  logic [ADDR_W-1:0] addr_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q, word_nxt;
  logic [ADDR_W:0]   words_q;
  logic              wr_en_q, done_q, b2_viol;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  imem_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start),
    .shift_i(shift),
    .byte_i (in_data),
    .word_o (word_nxt),
    .viol_o (b2_viol)
  );

  assign in_ready      = (state_q != S_WRITE);
  assign acc           = in_valid && in_ready;
  assign cnt_in        = {hi_q, in_data};
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign error         = (state_q == S_ERROR);
  assign done          = done_q;
  assign words_written = words_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    fin     = 1'b0;
    wr_go   = 1'b0;
    shift   = 1'b0;
    chk_en  = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (acc && in_data == SYNC_BYTE) begin
          state_d = S_ADDR_HI;
          start   = 1'b1;
        end
      end
      S_ADDR_HI: begin
        chk_en = acc;
        if (acc) state_d = |(in_data & ADDR_HI_MASK) ? S_ERROR : S_ADDR_LO;
      end
      S_ADDR_LO: begin
        chk_en = acc;
        if (acc) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        chk_en = acc;
        if (acc) state_d = S_CNT_LO;
      end
      S_CNT_LO: begin
        chk_en = acc;
        if (acc) begin
          if (cnt_in == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_IDLE;
            fin     = 1'b1;
`endif
          end else if (cnt_in > MAX_CNT) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_W2;
          end
        end
      end
      S_W2: begin
        chk_en = acc;
        shift  = acc;
        if (acc) state_d = b2_viol ? S_ERROR : S_W1;
      end
      S_W1: begin
        chk_en = acc;
        shift  = acc;
        if (acc) state_d = S_W0;
      end
      S_W0: begin
        chk_en = acc;
        shift  = acc;
        wr_go  = acc;
        if (acc) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (rem_q > 16'd1) begin
          state_d = S_W2;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_IDLE;
          fin     = 1'b1;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (acc) begin
          if (in_data == chk_q) begin
            state_d = S_IDLE;
            fin     = 1'b1;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // hi_q is shared: it holds ADDR_HI, then CNT_HI, each consumed one byte later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q      <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      words_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= fin;
      wr_en_q <= wr_go;
      if (start) words_q <= '0;
      if (acc && (state_q == S_ADDR_HI || state_q == S_CNT_HI)) hi_q <= in_data;
      if (acc && state_q == S_ADDR_LO) addr_q <= ADDR_W'({hi_q, in_data});
      if (acc && state_q == S_CNT_LO) rem_q <= cnt_in;
      if (wr_go) begin
        wr_addr_q <= addr_q;
        wr_data_q <= word_nxt;
      end
      if (state_q == S_WRITE) begin
        addr_q  <= addr_q + ADDR_W'(1);
        rem_q   <= rem_q - 16'd1;
        words_q <= words_q + (ADDR_W+1)'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         chk_q <= '0;
    else if (start)  chk_q <= '0;
    else if (chk_en) chk_q <= chk_q ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a stream-level frame parser predicts
// writes, done pulses and error level; one negedge process checks every write.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, busy, done, error;
  logic [11:0] wr_addr;
  logic [18:0] wr_data;
  logic [12:0] words_written;

  int          total = 0;
  int          bad = 0;
  logic [30:0] exp_q[$];
  logic [30:0] e;
  int          m_done, m_words, done_seen;
  bit          m_err;
  logic [11:0] last_wa;
  logic [18:0] last_wd;
  bit          prev_acc, prev_done;

  always #5 clk = ~clk;

  imem_program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_written(words_written)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // Stream-level reference: scan for SYNC, parse header, emit expected writes.
  function automatic void model(input logic [7:0] s[$]);
    int i = 0;
    while (i < s.size()) begin
      logic [7:0] ck;
      int a, n;
      bit bd;
      if (s[i] != 8'hA5) begin i++; continue; end
      i++; m_err = 0; m_words = 0; bd = 0;
      if (i + 4 > s.size()) break;
      if (s[i][7:4] != 4'd0) begin m_err = 1; i++; continue; end
      a  = {20'd0, s[i][3:0], s[i+1]};
      n  = {16'd0, s[i+2], s[i+3]};
      ck = s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
      i += 4;
      if (n > 4096) begin m_err = 1; continue; end
      for (int w = 0; w < n && !bd; w++) begin
        if (s[i][7:3] != 5'd0) begin
          bd = 1; i++;
        end else begin
          exp_q.push_back({12'(a), s[i][2:0], s[i+1], s[i+2]});
          ck ^= s[i] ^ s[i+1] ^ s[i+2];
          i += 3;
          a = (a + 1) % 4096;
          m_words++;
        end
      end
      if (bd) begin m_err = 1; continue; end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (s[i] == ck) m_done++; else m_err = 1;
      i++;
`else
      m_done++;
`endif
    end
  endfunction

  function automatic void add_ck(inout logic [7:0] s[$], input int from);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] c = 8'h00;
    for (int i = from; i < s.size(); i++) c ^= s[i];
    s.push_back(c);
`else
    if (from < 0) s.delete();
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_acc  = 0;
      prev_done = 0;
    end else begin
      chk("busy_err_excl", {31'd0, busy & error}, 0);
      if (wr_en) begin
        chk("wr_latency", {31'd0, prev_acc}, 1);
        chk("wr_in_ready", {31'd0, in_ready}, 0);
        chk("wr_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", {20'd0, wr_addr}, {20'd0, e[30:19]});
          chk("wr_data", {13'd0, wr_data}, {13'd0, e[18:0]});
        end
        last_wa = wr_addr;
        last_wd = wr_data;
      end
      if (done) begin
        done_seen++;
        chk("done_width", {31'd0, prev_done}, 0);
      end
      prev_done = done;
      prev_acc  = in_valid && in_ready;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bit rdy;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 50);
    chk("send_ready", {31'd0, rdy}, 1);
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [7:0] s[$], input int gap_at);
    done_seen = 0;
    m_done    = 0;
    model(s);
    foreach (s[i]) begin
      if (i == gap_at) begin
        repeat (5) @(posedge clk);
        #1;
      end
      send_byte(s[i]);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_count", done_seen, m_done);
    chk("error_level", {31'd0, error}, {31'd0, m_err});
    chk("words_written", {19'd0, words_written}, m_words);
    chk("busy_idle", {31'd0, busy}, 0);
    chk("in_ready_idle", {31'd0, in_ready}, 1);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] f[$];
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_words", {19'd0, words_written}, 0);
    chk("rst_wr_addr", {20'd0, wr_addr}, 0);
    chk("rst_wr_data", {13'd0, wr_data}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single word
    s = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h00, 8'h19, 8'h46};
    add_ck(s, 1);
    run(s, -1);
    chk("t1_addr", {20'd0, last_wa}, 32'h7);
    chk("t1_data", {13'd0, last_wd}, 32'h01946);
    chk("t1_words", {19'd0, words_written}, 1);

    // two words wrapping 4095 -> 0, with SYNC value as ordinary data
    s = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h05, 8'hA5, 8'h3C, 8'h00, 8'h12, 8'h34};
    add_ck(s, 1);
    run(s, -1);
    chk("t2_addr", {20'd0, last_wa}, 32'h0);
    chk("t2_data", {13'd0, last_wd}, 32'h01234);
    chk("t2_words", {19'd0, words_written}, 2);

    // junk then empty frame
    s = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h14, 8'h00, 8'h00};
    add_ck(s, 3);
    run(s, -1);
    chk("t3_error", {31'd0, error}, 0);
    chk("t3_words", {19'd0, words_written}, 0);

    // bad B2 then a good frame
    s = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h12, 8'h34};
    f = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h01, 8'h23, 8'h45};
    add_ck(f, 1);
    s = {s, f};
    run(s, -1);
    chk("t4_addr", {20'd0, last_wa}, 32'h020);
    chk("t4_data", {13'd0, last_wd}, 32'h12345);

    // count too large
    s = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h01};
    run(s, -1);
    chk("t5_error", {31'd0, error}, 1);

    // in_valid low for 5 cycles before B0
    s = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'h02, 8'hAB, 8'hCD};
    add_ck(s, 1);
    run(s, 7);
    chk("t6_addr", {20'd0, last_wa}, 32'h030);
    chk("t6_data", {13'd0, last_wd}, 32'h2ABCD);
    chk("t6_error", {31'd0, error}, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    s = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h00, 8'h19, 8'h46, 8'h58};
    run(s, -1);
    chk("t7_bad_ck_error", {31'd0, error}, 1);
`endif

    // reset mid-word: no write may appear
    s = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h12};
    foreach (s[i]) send_byte(s[i]);
    chk("t8_busy_before", {31'd0, busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t8_busy", {31'd0, busy}, 0);
    chk("t8_in_ready", {31'd0, in_ready}, 1);
    chk("t8_words", {19'd0, words_written}, 0);
    chk("t8_error", {31'd0, error}, 0);
    chk("t8_no_write", exp_q.size(), 0);

    s = '{8'hA5, 8'h00, 8'h07, 8'h00, 8'h01, 8'h00, 8'h19, 8'h46};
    add_ck(s, 1);
    run(s, -1);
    chk("t9_data", {13'd0, last_wd}, 32'h01946);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Byte-stream writer that fills the 4096 x 19-bit instruction memory before the CPU runs.
- Receives framed bytes over a valid/ready link, parses a header, packs every 3 bytes into one 19-bit instruction, and issues single-cycle write strobes.
- Sits between the host/UART byte source and the instruction memory write port.
- Holds the CPU off (busy) while a program image is in flight.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- ADDR_W, 12, instruction address width.
- DATA_W, 19, instruction width; legal range 17..24, so one word is always 3 bytes.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  single-cycle instruction memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  instruction to write
- busy  out  1  frame in progress; CPU must stay stalled
- done  out  1  one-cycle pulse, frame completed successfully
- error  out  1  level; frame aborted
- words_written  out  ADDR_W+1  words written in the current/last frame

Behaviour:
- Reset: all outputs 0 except in_ready=1. State IDLE, counters 0.
- Handshake: a byte transfers on a rising clk edge with in_valid && in_ready. in_valid may toggle freely.
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT groups of 3 bytes (B2, B1, B0).
- Word packing: wr_data = {B2[DATA_W-17:0], B1, B0}.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, W2, W1, W0, WRITE, (CHK), ERROR.
- IDLE: non-SYNC bytes are consumed and dropped. SYNC -> ADDR_HI, busy=1, words_written=0.
- ADDR_HI: bits [7:ADDR_W-8] must be 0, else ERROR.
- CNT: count is 16-bit.
  - CNT=0 -> done pulse, back to IDLE.
  - CNT>4096 -> ERROR.
- W2: unused upper bits must be 0, else ERROR.
- W0 accept -> WRITE.
- WRITE (1 cycle):
  - in_ready=0; wr_en=1 with the current addr and word.
  - addr increments modulo 2^ADDR_W; wrap 4095->0 is legal.
  - words_written++.
  - Next state: W2 if words remain, else done (or CHK).
- Latency: wr_en is asserted exactly 1 cycle after B0 is accepted. Back-to-back words take 4 cycles each.
- done: asserted the cycle the FSM returns to IDLE; busy falls the same cycle.
- ERROR:
  - error=1 and busy=0; in_ready=1 and bytes are discarded.
  - SYNC restarts the header: error clears, busy=1.
  - Already-written words are not rolled back.
- A SYNC value inside a frame is ordinary data, not a restart.
- Reset mid-frame: immediate return to IDLE; any partial word is lost and no write is issued.
- wr_addr and wr_data hold their last values when wr_en=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An extra byte follows the last word: the XOR of all bytes after SYNC (header and data).
  - The last WRITE goes to CHK. A matching byte gives done; a mismatch gives ERROR.
  - CNT=0 also goes to CHK.
- Undefined: no CHK state; the frame ends after the last WRITE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum typedef;
  - SYNC_BYTE default;
  - the IMEM_DEPTH=4096 constant;
  - the BYTES_PER_WORD=3 constant.
- Sub-module: imem_word_packer, a 3-byte shift/assemble register with a byte index and an upper-bit-violation flag. The FSM stays in the top module.

Test Plan:
- Single word: bytes A5 00 07 00 01 00 19 46 -> one wr_en, wr_addr=7, wr_data=19'h01946, done pulse, words_written=1.
- Two words at 4095 -> writes at 4095 then 0 (wrap), done, words_written=2.
- Junk 11 22 before A5, header 00 14 00 00 -> no writes, done pulse, no error.
- Bad B2=0x08 in word 1 -> error=1, no write. A following good A5 frame completes normally.
- CNT_HI/LO = 10 01 (>4096) -> error. in_valid held low for 5 cycles mid-word on a good frame -> same single write.
- IMEM_LOADER_CHECKSUM_EN: the single-word frame plus checksum byte 00^07^00^01^00^19^46=0x59 -> done. Sending 0x58 instead -> error.
